// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back select encoding.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } memtoreg_e;

  function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: 31 writable registers, one write port, two async read ports.
module regfile_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]      rdata_a,
  output logic [WIDTH-1:0]      rdata_b
);

  // $0 is hard-wired, so no storage is allocated for it.
  logic [WIDTH-1:0] mem [1:NREG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREG); i++) begin
        mem[i] <= '0;
      end
    end else if (we && !is_reg_zero(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (!is_reg_zero(raddr_a)) rdata_a = mem[raddr_a];
    if (!is_reg_zero(raddr_b)) rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, write qualification, sticky overflow flag and retired-write counter.
// Optional same-cycle read bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [WIDTH-1:0]      W_Dout,
  input  logic [WIDTH-1:0]      W_ALUout,
  input  logic                  W_Overflow,
  input  logic [REG_ADDR_W-1:0] W_Rw,
  input  logic                  W_RegWr,
  input  logic                  W_MemtoReg,
  input  logic [REG_ADDR_W-1:0] Ra,
  input  logic [REG_ADDR_W-1:0] Rb,
  output logic [WIDTH-1:0]      busA,
  output logic [WIDTH-1:0]      busB,
  output logic [WIDTH-1:0]      busW,
  input  logic                  Ovf_clr,
  output logic                  Ovf_flag,
  output logic [31:0]           Wr_count
);

  logic             we;
  logic             ovf_set;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             ovf_flag_q;
  logic [31:0]      wr_count_q;

  assign busW    = (memtoreg_e'(W_MemtoReg) == SEL_MEM) ? W_Dout : W_ALUout;
  assign we      = W_RegWr && !W_Overflow && !is_reg_zero(W_Rw);
  assign ovf_set = W_RegWr && W_Overflow;

  regfile_core #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_core (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .we      (we),
    .waddr   (W_Rw),
    .wdata   (busW),
    .raddr_a (Ra),
    .raddr_b (Rb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

`ifdef WB_BYPASS_EN
  // we already excludes $0 and overflow-suppressed writes, so neither is forwarded.
  assign busA = (we && (Ra == W_Rw)) ? busW : rd_a;
  assign busB = (we && (Rb == W_Rw)) ? busW : rd_b;
`else
  assign busA = rd_a;
  assign busB = rd_b;
`endif

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ovf_flag_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_flag_q <= 1'b1;
    end else if (Ovf_clr) begin
      ovf_flag_q <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_count_q <= '0;
    end else if (we) begin
      wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign Ovf_flag = ovf_flag_q;
  assign Wr_count = wr_count_q;

endmodule
